fifo_sync_flags: RTL and testbench

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and selectable first-word-fall-through (FWFT) read mode. It is the general-purpose synchronous buffer for same-clock producer/consumer paths in the datapath designs. It is the single-clock counterpart to the asynchronous FIFO and replaces ad-hoc register buffers.

---
 rtl/fifo_sync_flags_pkg.sv | 17 +
 rtl/fifo_ptr_counter.sv | 23 ++
 rtl/fifo_sync_flags.sv | 130 +++++++++++++
 tb/tb_fifo_sync_flags.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_flags_pkg.sv
// Shared defaults, width helper and read-mode constants for the single-clock FIFO.
package fifo_sync_flags_pkg;

  localparam int unsigned DefDataWidth     = 8;
  localparam int unsigned DefAddressWidth  = 4;
  localparam int unsigned DefAlmostEmptyTh = 2;

  // Read-mode selectors for the FWFT parameter
  localparam int unsigned FifoModeStd  = 0;
  localparam int unsigned FifoModeFwft = 1;

  // Occupancy needs one extra bit so that "full" (== depth) is representable
  function automatic int unsigned count_width(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// Binary wrap-around pointer with synchronous clear and count enable.
module fifo_ptr_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Clear_in,
  input  logic             Enable_in,
  output logic [WIDTH-1:0] Count_out
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      cnt_q <= '0;
    end else if (Enable_in) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign Count_out = cnt_q;

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags and
// selectable registered / first-word-fall-through read data.
module fifo_sync_flags
  import fifo_sync_flags_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DefDataWidth,
  parameter int unsigned ADDRESS_WIDTH   = DefAddressWidth,
  parameter int unsigned FIFO_DEPTH      = 1 << ADDRESS_WIDTH,
  parameter int unsigned ALMOST_FULL_TH  = FIFO_DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_TH = DefAlmostEmptyTh,
  parameter int unsigned FWFT            = FifoModeStd
) (
  input  logic                       Clk,
  input  logic                       Clear_in,
  input  logic [DATA_WIDTH-1:0]      Data_in,
  input  logic                       WriteEn_in,
  input  logic                       ReadEn_in,
  output logic [DATA_WIDTH-1:0]      Data_out,
  output logic                       Full_out,
  output logic                       Empty_out,
  output logic                       AlmostFull_out,
  output logic                       AlmostEmpty_out,
  output logic [ADDRESS_WIDTH:0]     Count_out,
  output logic                       Overflow_out,
  output logic                       Underflow_out
);

  localparam int unsigned CountWidth = count_width(ADDRESS_WIDTH);
  localparam logic [CountWidth-1:0] DepthC = CountWidth'(FIFO_DEPTH);
  localparam logic [CountWidth-1:0] AfThC  = CountWidth'(ALMOST_FULL_TH);
  localparam logic [CountWidth-1:0] AeThC  = CountWidth'(ALMOST_EMPTY_TH);

  if (ADDRESS_WIDTH < 2) begin : g_bad_aw
    $error("fifo_sync_flags: ADDRESS_WIDTH must be at least 2");
  end
  if (FIFO_DEPTH != (1 << ADDRESS_WIDTH)) begin : g_bad_depth
    $error("fifo_sync_flags: FIFO_DEPTH must equal 1 << ADDRESS_WIDTH");
  end

  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CountWidth-1:0]    count_q, count_d;
  logic                     full_q, empty_q, afull_q, aempty_q;
  logic                     ovf_q, udf_q;
  logic                     wr_acc, rd_acc;

  // Accepts use the registered flags, so a full FIFO still takes a read and
  // an empty one still takes a write in the same cycle.
  assign wr_acc = WriteEn_in & ~full_q & ~Clear_in;
  assign rd_acc = ReadEn_in & ~empty_q & ~Clear_in;

  fifo_ptr_counter #(
    .WIDTH(ADDRESS_WIDTH)
  ) u_wr_ptr (
    .Clk      (Clk),
    .Clear_in (Clear_in),
    .Enable_in(wr_acc),
    .Count_out(wr_ptr)
  );

  fifo_ptr_counter #(
    .WIDTH(ADDRESS_WIDTH)
  ) u_rd_ptr (
    .Clk      (Clk),
    .Clear_in (Clear_in),
    .Enable_in(rd_acc),
    .Count_out(rd_ptr)
  );

  always_ff @(posedge Clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr] <= Data_in;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CountWidth'(1);
      2'b01:   count_d = count_q - CountWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are derived from the next count so they track Count_out exactly
  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= (count_d == DepthC);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AfThC);
      aempty_q <= (count_d <= AeThC);
      ovf_q    <= ovf_q | (WriteEn_in & full_q);
      udf_q    <= udf_q | (ReadEn_in & empty_q);
    end
  end

  if (FWFT == FifoModeFwft) begin : g_fwft
    assign Data_out = mem_q[rd_ptr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge Clk) begin
      if (Clear_in) begin
        data_q <= '0;
      end else if (rd_acc) begin
        data_q <= mem_q[rd_ptr];
      end
    end

    assign Data_out = data_q;
  end

  assign Count_out       = count_q;
  assign Full_out        = full_q;
  assign Empty_out       = empty_q;
  assign AlmostFull_out  = afull_q;
  assign AlmostEmpty_out = aempty_q;
  assign Overflow_out    = ovf_q;
  assign Underflow_out   = udf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Drives a registered-read and an FWFT instance with identical stimulus and
// checks both against a queue-based model of the FIFO.
module tb_fifo_sync_flags;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       clr = 1'b0, we = 1'b0, re = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] s_data, f_data;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  always #5 clk = ~clk;

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .FWFT(0)) u_std (
    .Clk(clk), .Clear_in(clr), .Data_in(din), .WriteEn_in(we), .ReadEn_in(re),
    .Data_out(s_data), .Full_out(s_full), .Empty_out(s_empty), .AlmostFull_out(s_af),
    .AlmostEmpty_out(s_ae), .Count_out(s_count), .Overflow_out(s_ovf), .Underflow_out(s_udf)
  );

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .FWFT(1)) u_fwft (
    .Clk(clk), .Clear_in(clr), .Data_in(din), .WriteEn_in(we), .ReadEn_in(re),
    .Data_out(f_data), .Full_out(f_full), .Empty_out(f_empty), .AlmostFull_out(f_af),
    .AlmostEmpty_out(f_ae), .Count_out(f_count), .Overflow_out(f_ovf), .Underflow_out(f_udf)
  );

  // Reference model
  logic [7:0] mq[$];
  logic [7:0] m_data = 8'h00;
  bit         m_ovf = 1'b0, m_udf = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    bit         w, r, c;
    logic [7:0] d;
    int         cnt;
    bit         emp, ful, ovf, udf;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Applies the spec rules to the model using the inputs present at the edge
  task automatic model_edge();
    bit full_now, empty_now;
    full_now  = (mq.size() == Depth);
    empty_now = (mq.size() == 0);
    if (clr) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_data = 8'h00;
    end else begin
      if (re && !empty_now) m_data = mq.pop_front();
      if (we && !full_now) mq.push_back(din);
      if (we && full_now) m_ovf = 1'b1;
      if (re && empty_now) m_udf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ":std.count"}, 32'(s_count), 32'(n));
    chk({tag, ":std.empty"}, 32'(s_empty), 32'(n == 0));
    chk({tag, ":std.full"},  32'(s_full),  32'(n == Depth));
    chk({tag, ":std.afull"}, 32'(s_af),    32'(n >= Depth - 2));
    chk({tag, ":std.aempty"}, 32'(s_ae),   32'(n <= 2));
    chk({tag, ":std.ovf"},   32'(s_ovf),   32'(m_ovf));
    chk({tag, ":std.udf"},   32'(s_udf),   32'(m_udf));
    chk({tag, ":std.data"},  32'(s_data),  32'(m_data));
    chk({tag, ":fwft.count"}, 32'(f_count), 32'(n));
    chk({tag, ":fwft.empty"}, 32'(f_empty), 32'(n == 0));
    chk({tag, ":fwft.full"},  32'(f_full),  32'(n == Depth));
    chk({tag, ":fwft.afull"}, 32'(f_af),    32'(n >= Depth - 2));
    chk({tag, ":fwft.aempty"}, 32'(f_ae),   32'(n <= 2));
    chk({tag, ":fwft.ovf"},   32'(f_ovf),   32'(m_ovf));
    chk({tag, ":fwft.udf"},   32'(f_udf),   32'(m_udf));
    if (n != 0) chk({tag, ":fwft.data"}, 32'(f_data), 32'(mq[0]));
  endtask

  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c,
                      input string tag);
    we = w; re = r; din = d; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  initial begin
    // w r c  data    cnt emp ful ovf udf dat
    tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h22, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 6; i++) begin
      we = tbl[i].w; re = tbl[i].r; clr = tbl[i].c; din = tbl[i].d;
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tbl%0d.count", i), 32'(s_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.empty", i), 32'(s_empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d.full", i),  32'(s_full),  32'(tbl[i].ful));
      chk($sformatf("tbl%0d.ovf", i),   32'(s_ovf),   32'(tbl[i].ovf));
      chk($sformatf("tbl%0d.udf", i),   32'(s_udf),   32'(tbl[i].udf));
      chk($sformatf("tbl%0d.data", i),  32'(s_data),  32'(tbl[i].dat));
      we = 1'b0; re = 1'b0; clr = 1'b0;
    end

    step(1'b0, 1'b0, 8'h00, 1'b0, "idle");

    for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 8'(i), 1'b0, "fill");
    step(1'b1, 1'b0, 8'hFF, 1'b0, "overflow");
    step(1'b1, 1'b1, 8'hEE, 1'b0, "rw_full");
    for (int i = 0; i < Depth - 1; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "drain");
    step(1'b0, 1'b1, 8'h00, 1'b0, "underflow");
    step(1'b1, 1'b1, 8'h77, 1'b0, "rw_empty");
    step(1'b0, 1'b1, 8'h00, 1'b0, "pop77");

    step(1'b1, 1'b0, 8'hA5, 1'b0, "fwft_a5");
    chk("fwft_a5.head", 32'(f_data), 32'h0000_00A5);
    step(1'b0, 1'b1, 8'h00, 1'b0, "fwft_pop");

    step(1'b0, 1'b0, 8'h00, 1'b1, "clr_mid");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, "half");
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0, "steady");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "steady_drain");

    for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, "refill");
    step(1'b1, 1'b0, 8'h99, 1'b0, "overflow2");
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "to5");
    step(1'b1, 1'b0, 8'h55, 1'b1, "clr_wr");
    chk("clr_wr.count0", 32'(s_count), 32'h0);

    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i < 300) ? 65 : 35;
      step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < 50),
           8'($urandom), ($urandom_range(0, 63) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
